mem_store_split: RTL and testbench
==================================

MEM_STORE_SPLIT -- requirements
Module: mem_store_split

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, asynchronous, active-high.
REQ-003 store_i  input  1  store request from execute stage, valid this cycle.
REQ-004 size_i  input  2  access size: 0 byte, 1 halfword, 2 word, 3 reserved.
REQ-005 addr_i  input  32  byte address of the store.
REQ-006 wdata_i  input  32  store data, right-aligned.
REQ-007 data_mem_addr_o  output  32  byte address to 16-bit data memory, bit 0 always 0.
REQ-008 data_mem_wdata_o  output  16  write data lane.
REQ-009 data_mem_we_o  output  1  write enable.
REQ-010 data_mem_be_o  output  2  byte enables: bit0 = bits 7:0, bit1 = bits 15:8.
REQ-011 stall_o  output  1  hold upstream pipeline; request this cycle not fully accepted.
REQ-012 misalign_o  output  1  registered one-cycle pulse, rejected misaligned store.
REQ-013 store_cnt_o  output  16  count of completed stores, wraps at 16'hFFFF -> 0.

Function
REQ-014 FSM states: ST_IDLE, ST_W_HIGH; reset state ST_IDLE.
REQ-015 ST_IDLE, store_i=0: we=0, be=0, addr=0, wdata=0, stall_o=0; stay ST_IDLE.
REQ-016 ST_IDLE, byte store: same cycle we=1; addr={addr_i[31:1],1'b0}; wdata={wdata_i[7:0],wdata_i[7:0]}; be=2'b01 if addr_i[0]=0, else 2'b10; stall_o=0; stay ST_IDLE.
REQ-017 ST_IDLE, halfword store with addr_i[0]=0: same cycle we=1; addr=addr_i; wdata=wdata_i[15:0]; be=2'b11; stall_o=0; stay ST_IDLE.
REQ-018 ST_IDLE, word store with addr_i[0]=0: same cycle low beat (we=1, addr=addr_i, wdata=wdata_i[15:0], be=2'b11, stall_o=1); latch wdata_i[31:16] and addr_i+2; next state ST_W_HIGH.
REQ-019 ST_W_HIGH: we=1; addr=latched addr; wdata=latched high half; be=2'b11; stall_o=0; store_i ignored; next state ST_IDLE.
REQ-020 Word store latency: 2 cycles, low half first, then high half on consecutive cycles; no idle cycle is inserted between beats.
REQ-021 Halfword or word store with addr_i[0]=1: no write (we=0), stall_o=0, misalign_o=1 on the following cycle only, state ST_IDLE.
REQ-022 size_i=3 with store_i=1: treated as misaligned; same response as REQ-021.
REQ-023 Address increment for the high beat is modulo 2^32: addr_i=32'hFFFFFFFE gives high beat at 32'h00000000.
REQ-024 store_cnt_o increments by 1 on the cycle after a byte or halfword write, and on the cycle after the high beat of a word store; it does not increment after a low beat or after a rejected store.
REQ-025 Back-to-back stores: a store in the cycle after ST_W_HIGH is accepted normally; the upstream holds its request while stall_o=1.
REQ-026 Memory outputs in ST_IDLE are combinational from the current inputs; in ST_W_HIGH they depend on latched state only.

Reset
REQ-027 rst_i assertion forces, immediately and independent of clk_i: ST_IDLE, latched address and data = 0, misalign_o=0, store_cnt_o=0.
REQ-028 While rst_i=1: we=0, be=0, stall_o=0, and store_i is ignored.
REQ-029 Reset asserted in ST_W_HIGH drops the pending high beat; only the low half stays written, and the count does not increment.

Verification
REQ-030 Word store, addr=0x100, data=0xDEADBEEF -> cycle0: we=1, addr 0x100, wdata 0xBEEF, stall=1; cycle1: addr 0x102, wdata 0xDEAD, stall=0; count +1 after cycle1.
REQ-031 Byte store, addr=0x203, data=0x5A -> single cycle: addr 0x202, wdata 0x5A5A, be=2'b10, stall=0.
REQ-032 Halfword store at addr=0x101 -> we=0 throughout; misalign_o high exactly one cycle later; count unchanged.
REQ-033 Word store at 0xFFFFFFFE followed immediately by halfword store at 0x10 -> beats at 0xFFFFFFFE and 0x0, then halfword at 0x10 in the third cycle; count +2.
REQ-034 rst_i pulsed asynchronously during ST_W_HIGH -> we falls at once without a clock edge; no high beat; after release, state ST_IDLE and count=0.
REQ-035 65536 halfword stores -> store_cnt_o wraps from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/mem_store_split.sv
// mem_store_split: splits byte/halfword/word stores onto a 16-bit data
// memory port. Words go out as two consecutive beats, low half first; the
// upstream stage is stalled for the low beat. Misaligned and reserved-size
// stores are rejected with a one-cycle registered pulse.
module mem_store_split (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        store_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] data_mem_addr_o,
  output logic [15:0] data_mem_wdata_o,
  output logic        data_mem_we_o,
  output logic [1:0]  data_mem_be_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [15:0] store_cnt_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_W_HIGH = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      r_state;
  logic [31:0] r_hi_addr;
  logic [15:0] r_hi_data;
  logic        r_misalign;
  logic [15:0] r_cnt;

  logic [31:0] w_addr;
  logic [15:0] w_wdata;
  logic        w_we;
  logic [1:0]  w_be;
  logic        w_stall;
  logic        w_word_low;
  logic        w_done;
  logic        w_misalign;

  // Memory-port decode: combinational from inputs in ST_IDLE, from latched
  // state in ST_W_HIGH; everything is forced quiet while reset is held.
  always_comb begin
    w_addr     = '0;
    w_wdata    = '0;
    w_we       = 1'b0;
    w_be       = '0;
    w_stall    = 1'b0;
    w_word_low = 1'b0;
    w_done     = 1'b0;
    w_misalign = 1'b0;
    if (!rst_i) begin
      case (r_state)
        ST_IDLE: begin
          if (store_i) begin
            case (size_i)
              SZ_BYTE: begin
                w_we    = 1'b1;
                w_addr  = {addr_i[31:1], 1'b0};
                w_wdata = {wdata_i[7:0], wdata_i[7:0]};
                w_be    = addr_i[0] ? 2'b10 : 2'b01;
                w_done  = 1'b1;
              end
              SZ_HALF: begin
                if (!addr_i[0]) begin
                  w_we    = 1'b1;
                  w_addr  = addr_i;
                  w_wdata = wdata_i[15:0];
                  w_be    = 2'b11;
                  w_done  = 1'b1;
                end else begin
                  w_misalign = 1'b1;
                end
              end
              SZ_WORD: begin
                if (!addr_i[0]) begin
                  w_we       = 1'b1;
                  w_addr     = addr_i;
                  w_wdata    = wdata_i[15:0];
                  w_be       = 2'b11;
                  w_stall    = 1'b1;
                  w_word_low = 1'b1;
                end else begin
                  w_misalign = 1'b1;
                end
              end
              default: begin
                w_misalign = 1'b1;
              end
            endcase
          end
        end
        ST_W_HIGH: begin
          w_we    = 1'b1;
          w_addr  = r_hi_addr;
          w_wdata = r_hi_data;
          w_be    = 2'b11;
          w_done  = 1'b1;
        end
        default: begin
          w_we = 1'b0;
        end
      endcase
    end
  end

  // FSM, high-beat latch, misalign pulse and completed-store counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_hi_addr  <= '0;
      r_hi_data  <= '0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_word_low) begin
            r_hi_addr <= addr_i + 32'd2;
            r_hi_data <= wdata_i[31:16];
            r_state   <= ST_W_HIGH;
          end
        end
        ST_W_HIGH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      r_misalign <= w_misalign;
      if (w_done) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign data_mem_addr_o  = w_addr;
  assign data_mem_wdata_o = w_wdata;
  assign data_mem_we_o    = w_we;
  assign data_mem_be_o    = w_be;
  assign stall_o          = w_stall;
  assign misalign_o       = r_misalign;
  assign store_cnt_o      = r_cnt;

endmodule

// File: tb/tb_mem_store_split.sv
// Scoreboard bench for mem_store_split: stimulus pushes expected write beats,
// a negedge monitor pops and compares every beat the DUT presents.
module tb_mem_store_split;

  logic        clk;
  logic        rst;
  logic        store;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_we;
  logic [1:0]  m_be;
  logic        stall;
  logic        misalign;
  logic [15:0] cnt;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        stall;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_store_split dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .store_i          (store),
    .size_i           (size),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .data_mem_addr_o  (m_addr),
    .data_mem_wdata_o (m_wdata),
    .data_mem_we_o    (m_we),
    .data_mem_be_o    (m_be),
    .stall_o          (stall),
    .misalign_o       (misalign),
    .store_cnt_o      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [15:0] d, input logic [1:0] be,
                      input logic st);
    beat_t b;
    b.addr = a; b.wdata = d; b.be = be; b.stall = st;
    exp_q.push_back(b);
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic st, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    store = st; size = sz; addr = a; wdata = d;
  endtask

  // Monitor: every presented write beat must match the head of the queue.
  always @(negedge clk) begin
    if (m_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", m_addr, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_addr", m_addr, e.addr);
        check("beat_wdata", {16'h0, m_wdata}, {16'h0, e.wdata});
        check("beat_be", {30'h0, m_be}, {30'h0, e.be});
        check("beat_stall", {31'h0, stall}, {31'h0, e.stall});
      end
    end
  end

  initial begin
    rst = 1'b1; store = 1'b1; size = 2'd2; addr = 32'h500; wdata = 32'h1;
    #12;
    check("rst_we", {31'h0, m_we}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_be", {30'h0, m_be}, 32'h0);
    check("rst_cnt", {16'h0, cnt}, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("idle_addr", m_addr, 32'h0);
    check("idle_we", {31'h0, m_we}, 32'h0);

    // byte at odd and even address
    push(32'h202, 16'h5A5A, 2'b10, 1'b0);
    drive(1'b1, 2'd0, 32'h203, 32'h5A);
    push(32'h202, 16'hA5A5, 2'b01, 1'b0);
    drive(1'b1, 2'd0, 32'h202, 32'h1234_56A5);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("cnt_bytes", {16'h0, cnt}, 32'd2);

    // aligned halfword
    push(32'h300, 16'hBABE, 2'b11, 1'b0);
    drive(1'b1, 2'd1, 32'h300, 32'hCAFE_BABE);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("cnt_half", {16'h0, cnt}, 32'd3);

    // word store, request held while stalled
    push(32'h100, 16'hBEEF, 2'b11, 1'b1);
    push(32'h102, 16'hDEAD, 2'b11, 1'b0);
    drive(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF);
    drive(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF);
    check("cnt_after_low", {16'h0, cnt}, 32'd3);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("cnt_after_word", {16'h0, cnt}, 32'd4);

    // rejected stores: odd halfword, reserved size, odd word
    drive(1'b1, 2'd1, 32'h101, 32'h1111);
    check("mis_half_stall", {31'h0, stall}, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("mis_half_pulse", {31'h0, misalign}, 32'h1);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("mis_half_drop", {31'h0, misalign}, 32'h0);
    drive(1'b1, 2'd3, 32'h100, 32'h2222);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("mis_rsvd_pulse", {31'h0, misalign}, 32'h1);
    drive(1'b1, 2'd2, 32'h103, 32'h3333_4444);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("mis_word_pulse", {31'h0, misalign}, 32'h1);
    check("cnt_after_mis", {16'h0, cnt}, 32'd4);

    // word at top of address space, then halfword back-to-back
    push(32'hFFFF_FFFE, 16'h2222, 2'b11, 1'b1);
    push(32'h0000_0000, 16'h1111, 2'b11, 1'b0);
    push(32'h0000_0010, 16'h7777, 2'b11, 1'b0);
    drive(1'b1, 2'd2, 32'hFFFF_FFFE, 32'h1111_2222);
    drive(1'b1, 2'd2, 32'hFFFF_FFFE, 32'h1111_2222);
    drive(1'b1, 2'd1, 32'h10, 32'h0000_7777);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("cnt_b2b", {16'h0, cnt}, 32'd6);

    // asynchronous reset during the high beat
    push(32'h400, 16'h5678, 2'b11, 1'b1);
    drive(1'b1, 2'd2, 32'h400, 32'h1234_5678);
    drive(1'b1, 2'd2, 32'h400, 32'h1234_5678);
    check("hi_beat_we", {31'h0, m_we}, 32'h1);
    check("hi_beat_addr", m_addr, 32'h402);
    #1;
    rst = 1'b1;
    #1;
    check("async_we", {31'h0, m_we}, 32'h0);
    check("async_stall", {31'h0, stall}, 32'h0);
    check("async_cnt", {16'h0, cnt}, 32'h0);
    drive(1'b1, 2'd2, 32'h400, 32'h1234_5678);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("post_rst_we", {31'h0, m_we}, 32'h0);
    check("post_rst_cnt", {16'h0, cnt}, 32'h0);

    // counter wrap over 65536 halfword stores
    for (int unsigned i = 0; i < 65536; i++) begin
      push(32'h20, i[15:0], 2'b11, 1'b0);
      drive(1'b1, 2'd1, 32'h20, i);
      if (i == 65535) begin
        check("cnt_ffff", {16'h0, cnt}, 32'h0000_FFFF);
      end
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("cnt_wrap", {16'h0, cnt}, 32'h0);

    drive(1'b0, 2'd0, 32'h0, 32'h0);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
